// File: rtl/iic_frame_ctrl_module_if.sv
// rtl/iic_frame_ctrl_module_if.sv - signal bundle between start/valid detection, frame controller and EEPROM datapath
interface iic_frame_ctrl_module_if;
    logic       iic_valid;
    logic       iic_start_rising_r;
    logic       sda_in;
    logic       ee_wbusy_comb;
    logic [7:0] iic_rdata;
    logic [7:0] iic_cmd_reg;
    logic       iic_bitcnt_is_0;
    logic       sda_oe;
    logic       iic_rw;
    logic [7:0] iic_addr;
    logic [7:0] iic_wdata;
    logic       iic_wr_stb;
    logic       iic_rd_stb;

    modport slave (
        input  iic_valid, iic_start_rising_r, sda_in, ee_wbusy_comb, iic_rdata,
        output iic_cmd_reg, iic_bitcnt_is_0, sda_oe, iic_rw, iic_addr, iic_wdata,
               iic_wr_stb, iic_rd_stb
    );

    modport master (
        output iic_valid, iic_start_rising_r, sda_in, ee_wbusy_comb, iic_rdata,
        input  iic_cmd_reg, iic_bitcnt_is_0, sda_oe, iic_rw, iic_addr, iic_wdata,
               iic_wr_stb, iic_rd_stb
    );
endinterface

// File: rtl/iic_frame_ctrl_module.sv
// rtl/iic_frame_ctrl_module.sv - I2C slave frame controller (define IIC_ADDR_AUTOINC_EN for word-address auto-increment)
module iic_frame_ctrl_module #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000,
    parameter int         ADDR_W   = 8
) (
    input  logic                   iic_clk_c,
    input  logic                   iic_rst_n,
    iic_frame_ctrl_module_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          tx_q, tx_d;
    logic                sda_oe_q, sda_oe_d;
    logic                wr_stb_q, wr_stb_d;
    logic                rd_stb_q, rd_stb_d;
    logic                rx_state;
    logic [7:0]          byte_rx;

    assign rx_state = (state_q == DEV) || (state_q == WADDR) || (state_q == WDATA);
    assign byte_rx  = {cmd_q[6:0], bus.sda_in};

    always_ff @(posedge iic_clk_c) begin
        if (!iic_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            sda_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            sda_oe_q  <= sda_oe_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;

        if (!bus.iic_valid) begin
            state_d = IDLE;
        end else if (bus.iic_start_rising_r) begin
            state_d   = DEV;
            bit_cnt_d = 3'd7;
        end else begin
            if (rx_state) begin
                cmd_d     = byte_rx;
                bit_cnt_d = bit_cnt_q - 3'd1;
            end
            unique case (state_q)
                IDLE: ;
                DEV: if (bit_cnt_q == 3'd0) begin
                    // A busy EEPROM leaves the address unacknowledged so the master can poll.
                    if (byte_rx[7:1] == DEV_ADDR && !bus.ee_wbusy_comb) begin
                        rw_d     = byte_rx[0];
                        rd_stb_d = byte_rx[0];
                        state_d  = DEV_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DEV_ACK: begin
                    bit_cnt_d = 3'd7;
                    if (rw_q) begin
                        tx_d    = bus.iic_rdata;
                        state_d = RDATA;
                    end else begin
                        state_d = WADDR;
                    end
                end
                WADDR: if (bit_cnt_q == 3'd0) begin
                    addr_d  = byte_rx;
                    state_d = WADDR_ACK;
                end
                WDATA: if (bit_cnt_q == 3'd0) begin
                    wdata_d  = byte_rx;
                    wr_stb_d = 1'b1;
                    state_d  = WDATA_ACK;
                end
                WADDR_ACK, WDATA_ACK: begin
                    bit_cnt_d = 3'd7;
                    state_d   = WDATA;
                end
                RDATA: begin
                    tx_d      = {tx_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) state_d = RDATA_ACK;
                end
                RDATA_ACK: begin
                    if (!bus.sda_in) begin
                        tx_d      = bus.iic_rdata;
                        rd_stb_d  = 1'b1;
                        bit_cnt_d = 3'd7;
                        state_d   = RDATA;
`ifdef IIC_ADDR_AUTOINC_EN
                        addr_d    = addr_q + 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef IIC_ADDR_AUTOINC_EN
        // The word address moves on once the write strobe has been seen, even if the frame ends.
        if (wr_stb_q) addr_d = addr_q + 1'b1;
`endif

        sda_oe_d = (state_d == DEV_ACK) || (state_d == WADDR_ACK) || (state_d == WDATA_ACK)
                || ((state_d == RDATA) && !tx_d[7]);
    end

    assign bus.iic_cmd_reg     = cmd_q;
    assign bus.iic_bitcnt_is_0 = rx_state && (bit_cnt_q == 3'd0);
    assign bus.sda_oe          = sda_oe_q;
    assign bus.iic_rw          = rw_q;
    assign bus.iic_addr        = addr_q;
    assign bus.iic_wdata       = wdata_q;
    assign bus.iic_wr_stb      = wr_stb_q;
    assign bus.iic_rd_stb      = rd_stb_q;
endmodule

// File: tb/tb_iic_frame_ctrl_module.sv
// tb/tb_iic_frame_ctrl_module.sv - randomized frame-level bench for iic_frame_ctrl_module
module tb_iic_frame_ctrl_module;
    localparam logic [6:0] DEV = 7'b1010000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iic_frame_ctrl_module_if bus ();

    iic_frame_ctrl_module #(.DEV_ADDR(DEV), .ADDR_W(8)) dut (
        .iic_clk_c (clk),
        .iic_rst_n (rst_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] addr_m;
    logic [7:0] wdata_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bump_addr;
`ifdef IIC_ADDR_AUTOINC_EN
        addr_m = addr_m + 8'd1;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.sda_in = b[i];
            check("bitcnt_is_0", bus.iic_bitcnt_is_0, (i == 0));
            check("rx_sda_oe", bus.sda_oe, 0);
            step();
        end
        check("cmd_reg", bus.iic_cmd_reg, b);
    endtask

    task automatic do_start;
        bus.iic_valid = 1'b1;
        bus.iic_start_rising_r = 1'b1;
        bus.sda_in = 1'($urandom);
        step();
        bus.iic_start_rising_r = 1'b0;
        check("start_addr_kept", bus.iic_addr, addr_m);
    endtask

    task automatic do_stop;
        bus.iic_valid = 1'b0;
        step();
        check("idle_sda_oe", bus.sda_oe, 0);
        check("idle_bitcnt", bus.iic_bitcnt_is_0, 0);
        check("idle_wr_stb", bus.iic_wr_stb, 0);
        check("idle_rd_stb", bus.iic_rd_stb, 0);
        check("idle_addr", bus.iic_addr, addr_m);
    endtask

    task automatic dev_phase(input logic [7:0] b, input bit busy, output bit acked);
        bus.ee_wbusy_comb = busy;
        send_byte(b);
        acked = (b[7:1] == DEV) && !busy;
        check("dev_ack", bus.sda_oe, acked);
        check("dev_rd_stb", bus.iic_rd_stb, acked && b[0]);
        if (acked) check("rw", bus.iic_rw, b[0]);
        bus.sda_in = 1'b1;
        step();
    endtask

    // cut_byte < 0: no interruption; otherwise stop after cut_bit bits of that data byte
    task automatic write_frame(input bit skip_start, input logic [7:0] waddr, input int nbytes,
                               input int fixed_data, input int cut_byte, input int cut_bit,
                               input bit restart);
        bit acked;
        logic [7:0] d;
        if (!skip_start) do_start();
        dev_phase({DEV, 1'b0}, 1'b0, acked);
        bus.ee_wbusy_comb = 1'($urandom);
        send_byte(waddr);
        addr_m = waddr;
        check("waddr_ack", bus.sda_oe, 1);
        check("waddr", bus.iic_addr, addr_m);
        bus.sda_in = 1'b1;
        step();
        for (int k = 0; k < nbytes; k++) begin
            d = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom);
            if (k == cut_byte) begin
                for (int j = 7; j > 7 - cut_bit; j--) begin
                    bus.sda_in = d[j];
                    step();
                end
                if (restart) begin
                    do_start();
                    check("restart_bitcnt", bus.iic_bitcnt_is_0, 0);
                end else begin
                    bus.iic_valid = 1'b0;
                    step();
                end
                check("cut_wr_stb", bus.iic_wr_stb, 0);
                check("cut_wdata", bus.iic_wdata, wdata_m);
                if (!restart) begin
                    step();
                    check("cut_wr_stb_late", bus.iic_wr_stb, 0);
                end
                return;
            end
            send_byte(d);
            wdata_m = d;
            check("wdata_ack", bus.sda_oe, 1);
            check("wr_stb", bus.iic_wr_stb, 1);
            check("wdata", bus.iic_wdata, wdata_m);
            check("addr_at_stb", bus.iic_addr, addr_m);
            bus.sda_in = 1'b1;
            step();
            bump_addr();
            check("wr_stb_width", bus.iic_wr_stb, 0);
            check("addr_after_wr", bus.iic_addr, addr_m);
        end
    endtask

    task automatic read_frame(input int nbytes, input int first_data);
        bit acked;
        logic [7:0] rd;
        rd = (first_data >= 0) ? 8'(first_data) : 8'($urandom);
        bus.iic_rdata = rd;
        do_start();
        dev_phase({DEV, 1'b1}, 1'b0, acked);
        for (int k = 0; k < nbytes; k++) begin
            for (int i = 7; i >= 0; i--) begin
                check("rd_sda_oe", bus.sda_oe, !rd[i]);
                if (i == 7) check("rd_stb_reload", bus.iic_rd_stb, (k != 0));
                if (i == 6) check("rd_stb_width", bus.iic_rd_stb, 0);
                bus.sda_in = 1'($urandom);
                step();
            end
            check("rd_ack_release", bus.sda_oe, 0);
            rd = 8'($urandom);
            bus.iic_rdata = rd;
            bus.sda_in = (k == nbytes - 1);
            step();
            if (k != nbytes - 1) bump_addr();
            check("rd_addr", bus.iic_addr, addr_m);
        end
        check("rd_end_sda_oe", bus.sda_oe, 0);
        check("rd_end_rd_stb", bus.iic_rd_stb, 0);
    endtask

    initial begin
        bit acked;
        logic [7:0] b;
        int mode;
        rst_n = 1'b0;
        bus.iic_valid = 1'b1;
        bus.iic_start_rising_r = 1'b1;
        bus.sda_in = 1'b1;
        bus.ee_wbusy_comb = 1'b0;
        bus.iic_rdata = 8'h00;
        addr_m = 8'h00;
        wdata_m = 8'h00;
        step();
        step();
        check("rst_cmd_reg", bus.iic_cmd_reg, 0);
        check("rst_bitcnt", bus.iic_bitcnt_is_0, 0);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_rw", bus.iic_rw, 0);
        check("rst_addr", bus.iic_addr, 0);
        check("rst_wdata", bus.iic_wdata, 0);
        check("rst_wr_stb", bus.iic_wr_stb, 0);
        check("rst_rd_stb", bus.iic_rd_stb, 0);
        bus.iic_start_rising_r = 1'b0;
        bus.iic_valid = 1'b0;
        rst_n = 1'b1;
        step();

        write_frame(1'b0, 8'h12, 1, 8'h5A, -1, 0, 1'b0);
        do_stop();
        read_frame(2, 8'hC3);
        do_stop();
        do_start();
        dev_phase(8'hA0, 1'b1, acked);
        do_stop();
        write_frame(1'b0, 8'hFF, 1, 8'hFF, -1, 0, 1'b0);
        do_stop();
        write_frame(1'b0, 8'($urandom), 2, -1, 1, 4, 1'b0);
        do_stop();
        write_frame(1'b0, 8'hFF, 2, -1, 0, $urandom_range(1, 7), 1'b1);
        write_frame(1'b1, 8'hFF, 2, -1, -1, 0, 1'b0);
        do_stop();

        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    write_frame(1'b0, 8'($urandom), $urandom_range(1, 3), -1, -1, 0, 1'b0);
                    do_stop();
                end
                1: begin
                    read_frame($urandom_range(1, 3), -1);
                    do_stop();
                end
                2: begin
                    b = 8'($urandom);
                    do_start();
                    dev_phase(b, 1'($urandom), acked);
                    if (!acked) do_stop();
                    else begin
                        bus.iic_valid = 1'b0;
                        step();
                    end
                end
                default: begin
                    write_frame(1'b0, 8'($urandom), 2, -1, $urandom_range(0, 1),
                                $urandom_range(1, 7), 1'b0);
                    do_stop();
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
